fifo_multi_grant_selector: RTL and testbench



---
 rtl/fifo_multi_grant_selector_pkg.sv | 21 ++
 rtl/fifo_multi_grant_selector_window_select.sv | 36 +++
 rtl/fifo_multi_grant_selector.sv | 138 +++++++++++++
 tb/tb_fifo_multi_grant_selector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_multi_grant_selector_pkg.sv
// Shared types and helpers for the multi-grant circular queue selector.
// Lane slicing macro keeps per-lane index extraction uniform.
`ifndef FIFO_MULTI_GRANT_SELECTOR_PKG_SV
`define FIFO_MULTI_GRANT_SELECTOR_PKG_SV

`define FMGS_LANE(k, aw) ((k)*(aw)) +: (aw)

package fifo_multi_grant_selector_pkg;

  typedef enum logic {
    DIR_HEAD = 1'b0,
    DIR_TAIL = 1'b1
  } dir_e;

  function automatic int slots_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

`endif

// File: rtl/fifo_multi_grant_selector_window_select.sv
// First-match search over a circular window of a candidate mask.
// Walks forward from start (head order) or backward (tail order).
module circular_window_select
  import fifo_multi_grant_selector_pkg::*;
#(
  parameter int AW = 3,
  localparam int SLOTS = 1 << AW
) (
  input  logic [SLOTS-1:0] cand_i,
  input  logic [AW-1:0]    start_i,
  input  logic [AW:0]      len_i,
  input  dir_e             dir_i,
  output logic             valid_o,
  output logic [AW-1:0]    index_o
);

  logic [AW-1:0] idx;

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    idx     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (dir_i == DIR_TAIL) begin
        idx = start_i - AW'(i);
      end else begin
        idx = start_i + AW'(i);
      end
      if (!valid_o && ((AW+1)'(i) < len_i) && cand_i[idx]) begin
        valid_o = 1'b1;
        index_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_multi_grant_selector.sv
// Circular queue owner granting up to NUM_GRANTS ready slots per cycle.
// Grants are registered; head retirement uses a valid/ack handshake.
module fifo_multi_grant_selector
  import fifo_multi_grant_selector_pkg::*;
#(
  parameter int    ADDR_WIDTH = 3,
  parameter int    NUM_GRANTS = 2,
  parameter string CLOSEST_TO = "head"
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [ADDR_WIDTH-1:0]            alloc_index,
  input  logic                             ready_set_valid,
  input  logic [ADDR_WIDTH-1:0]            ready_set_index,
  input  logic                             issue_stall,
  output logic [NUM_GRANTS-1:0]            grant_valid,
  output logic [NUM_GRANTS*ADDR_WIDTH-1:0] grant_index,
  output logic                             retire_valid,
  output logic [ADDR_WIDTH-1:0]            retire_index,
  input  logic                             retire_ack,
  output logic [ADDR_WIDTH-1:0]            head,
  output logic [ADDR_WIDTH-1:0]            tail,
  output logic [ADDR_WIDTH:0]              count
);

  localparam int   AW    = ADDR_WIDTH;
  localparam int   SLOTS = slots_of(AW);
  localparam dir_e DIR   = (CLOSEST_TO == "tail") ? DIR_TAIL : DIR_HEAD;

  logic [AW-1:0]            head_q, head_d;
  logic [AW-1:0]            tail_q, tail_d;
  logic [AW:0]              count_q, count_d;
  logic [SLOTS-1:0]         occ_q, occ_d;
  logic [SLOTS-1:0]         rdy_q, rdy_d;
  logic [SLOTS-1:0]         iss_q, iss_d;
  logic [NUM_GRANTS-1:0]    gv_q, gv_d;
  logic [NUM_GRANTS*AW-1:0] gi_q, gi_d;

  logic                     alloc_fire;
  logic                     retire_fire;
  logic [AW-1:0]            start;
  logic [NUM_GRANTS-1:0]    sel_v;
  logic [NUM_GRANTS*AW-1:0] sel_i;
  logic [SLOTS-1:0]         mask [NUM_GRANTS+1];

  assign alloc_ready  = (count_q != (AW+1)'(SLOTS));
  assign alloc_index  = tail_q;
  assign retire_valid = occ_q[head_q] & iss_q[head_q];
  assign retire_index = head_q;
  assign head         = head_q;
  assign tail         = tail_q;
  assign count        = count_q;
  assign grant_valid  = gv_q;
  assign grant_index  = gi_q;

  assign alloc_fire  = alloc_valid & alloc_ready;
  assign retire_fire = retire_valid & retire_ack;

  assign start   = (DIR == DIR_TAIL) ? tail_q - AW'(1) : head_q;
  assign mask[0] = occ_q & rdy_q & ~iss_q;

  // Each lane sees the candidates left over after earlier lanes won.
  for (genvar g = 0; g < NUM_GRANTS; g++) begin : g_lane
    circular_window_select #(.AW(AW)) u_sel (
      .cand_i  (mask[g]),
      .start_i (start),
      .len_i   (count_q),
      .dir_i   (DIR),
      .valid_o (sel_v[g]),
      .index_o (sel_i[`FMGS_LANE(g, AW)])
    );
    assign mask[g+1] = mask[g] &
      ~(sel_v[g] ? (SLOTS'(1) << sel_i[`FMGS_LANE(g, AW)]) : '0);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    rdy_d   = rdy_q;
    iss_d   = iss_q;
    gv_d    = gv_q;
    gi_d    = gi_q;
    count_d = count_q + (AW+1)'(alloc_fire) - (AW+1)'(retire_fire);
    if (ready_set_valid && occ_q[ready_set_index] &&
        !iss_q[ready_set_index]) begin
      rdy_d[ready_set_index] = 1'b1;
    end
    if (!issue_stall) begin
      gv_d = sel_v;
      gi_d = sel_i;
      for (int k = 0; k < NUM_GRANTS; k++) begin
        if (sel_v[k]) begin
          iss_d[sel_i[`FMGS_LANE(k, AW)]] = 1'b1;
          rdy_d[sel_i[`FMGS_LANE(k, AW)]] = 1'b0;
        end
      end
    end
    if (retire_fire) begin
      occ_d[head_q] = 1'b0;
      rdy_d[head_q] = 1'b0;
      iss_d[head_q] = 1'b0;
      head_d        = head_q + AW'(1);
    end
    if (alloc_fire) begin
      occ_d[tail_q] = 1'b1;
      rdy_d[tail_q] = 1'b0;
      iss_d[tail_q] = 1'b0;
      tail_d        = tail_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      rdy_q   <= '0;
      iss_q   <= '0;
      gv_q    <= '0;
      gi_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      rdy_q   <= rdy_d;
      iss_q   <= iss_d;
      gv_q    <= gv_d;
      gi_q    <= gi_d;
    end
  end

endmodule

// File: tb/tb_fifo_multi_grant_selector.sv
// Scoreboard bench: head- and tail-priority instances share one stimulus.
// Expected grants are queued at stimulus time and popped after each edge.
module tb_fifo_multi_grant_selector;

  localparam int AW = 3;
  localparam int NG = 2;

  logic clock = 1'b0;
  logic reset, flush, alloc_valid, ready_set_valid, issue_stall, retire_ack;
  logic [AW-1:0] ready_set_index;

  logic          h_ar, t_ar, h_rv, t_rv;
  logic [AW-1:0] h_ai, t_ai, h_ri, t_ri, h_hd, t_hd, h_tl, t_tl;
  logic [AW:0]   h_cnt, t_cnt;
  logic [NG-1:0] h_gv, t_gv;
  logic [NG*AW-1:0] h_gi, t_gi;

  typedef struct {
    logic [NG-1:0]    gv_h;
    logic [NG*AW-1:0] gi_h;
    logic [NG-1:0]    gv_t;
    logic [NG*AW-1:0] gi_t;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fifo_multi_grant_selector #(.ADDR_WIDTH(AW), .NUM_GRANTS(NG),
                              .CLOSEST_TO("head")) u_head (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(h_ar), .alloc_index(h_ai),
    .ready_set_valid(ready_set_valid), .ready_set_index(ready_set_index),
    .issue_stall(issue_stall), .grant_valid(h_gv), .grant_index(h_gi),
    .retire_valid(h_rv), .retire_index(h_ri), .retire_ack(retire_ack),
    .head(h_hd), .tail(h_tl), .count(h_cnt)
  );

  fifo_multi_grant_selector #(.ADDR_WIDTH(AW), .NUM_GRANTS(NG),
                              .CLOSEST_TO("tail")) u_tail (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(t_ar), .alloc_index(t_ai),
    .ready_set_valid(ready_set_valid), .ready_set_index(ready_set_index),
    .issue_stall(issue_stall), .grant_valid(t_gv), .grant_index(t_gi),
    .retire_valid(t_rv), .retire_index(t_ri), .retire_ack(retire_ack),
    .head(t_hd), .tail(t_tl), .count(t_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [NG-1:0] gvh, input logic [NG*AW-1:0] gih,
                      input logic [NG-1:0] gvt, input logic [NG*AW-1:0] git);
    exp_t e;
    e.gv_h = gvh; e.gi_h = gih; e.gv_t = gvt; e.gi_t = git;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      chk({tag, "_gv_head"}, 32'(h_gv), 32'(e.gv_h));
      chk({tag, "_gi_head"}, 32'(h_gi), 32'(e.gi_h));
      chk({tag, "_gv_tail"}, 32'(t_gv), 32'(e.gv_t));
      chk({tag, "_gi_tail"}, 32'(t_gi), 32'(e.gi_t));
    end
  endtask

  task automatic rset(input int idx, input logic stall);
    ready_set_valid = 1'b1;
    ready_set_index = AW'(idx);
    issue_stall     = stall;
    tick();
    ready_set_valid = 1'b0;
  endtask

  task automatic allocs(input int n);
    alloc_valid = 1'b1;
    repeat (n) tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1; alloc_valid = 1'b1;
    ready_set_valid = 1'b1; ready_set_index = 3'd0;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; ready_set_valid = 1'b0;
    chk({tag, "_count"}, 32'(h_cnt), 0);
    chk({tag, "_gv"}, 32'(h_gv), 0);
    chk({tag, "_rv"}, 32'(h_rv), 0);
    chk({tag, "_tail"}, 32'(h_tl), 0);
    chk({tag, "_count_t"}, 32'(t_cnt), 0);
    tick();
    chk({tag, "_gv_after"}, 32'(h_gv), 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
    ready_set_valid = 1'b0; ready_set_index = '0;
    issue_stall = 1'b0; retire_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 32'(h_cnt), 0);
    chk("rst_ar", 32'(h_ar), 1);
    chk("rst_rv", 32'(h_rv), 0);
    chk("rst_gv", 32'(h_gv), 0);
    chk("rst_gi", 32'(h_gi), 0);

    allocs(8);
    chk("full_count", 32'(h_cnt), 8);
    chk("full_ar", 32'(h_ar), 0);
    chk("full_tail", 32'(h_tl), 0);
    chk("full_head", 32'(h_hd), 0);
    allocs(1);
    chk("refuse_count", 32'(h_cnt), 8);
    chk("refuse_tail", 32'(h_tl), 0);

    rset(1, 1'b1); rset(3, 1'b1); rset(5, 1'b1); rset(7, 1'b1);
    issue_stall = 1'b0;
    push(2'b11, 6'(3*8+1), 2'b11, 6'(5*8+7));
    push(2'b11, 6'(7*8+5), 2'b11, 6'(1*8+3));
    push(2'b00, 6'd0,      2'b00, 6'd0);
    drain("odd");
    chk("odd_rv", 32'(h_rv), 0);

    do_flush("flush1");

    allocs(6);
    for (int i = 0; i < 6; i++) rset(i, 1'b0);
    repeat (4) tick();
    retire_ack = 1'b1;
    repeat (6) tick();
    retire_ack = 1'b0;
    chk("wrap_head", 32'(h_hd), 6);
    chk("wrap_count0", 32'(h_cnt), 0);
    allocs(4);
    chk("wrap_tail", 32'(h_tl), 2);
    chk("wrap_count", 32'(h_cnt), 4);
    rset(0, 1'b1); rset(6, 1'b1); rset(3, 1'b1);
    issue_stall = 1'b0;
    push(2'b11, 6'(0*8+6), 2'b11, 6'(6*8+0));
    push(2'b00, 6'd0,      2'b00, 6'd0);
    push(2'b00, 6'd0,      2'b00, 6'd0);
    drain("wrap");

    allocs(3);
    rset(7, 1'b0);
    push(2'b01, 6'd7, 2'b01, 6'd7);
    drain("pre_stall");
    rset(2, 1'b1);
    push(2'b01, 6'd7, 2'b01, 6'd7);
    drain("hold1");
    rset(4, 1'b1);
    push(2'b01, 6'd7, 2'b01, 6'd7);
    drain("hold2");
    issue_stall = 1'b1;
    push(2'b01, 6'd7, 2'b01, 6'd7);
    drain("hold3");
    issue_stall = 1'b0;
    push(2'b11, 6'(4*8+2), 2'b11, 6'(2*8+4));
    push(2'b00, 6'd0,      2'b00, 6'd0);
    drain("release");

    allocs(1);
    chk("f2_count", 32'(h_cnt), 8);
    chk("f2_ar", 32'(h_ar), 0);
    chk("f2_rv", 32'(h_rv), 1);
    alloc_valid = 1'b1; retire_ack = 1'b1;
    tick();
    alloc_valid = 1'b0; retire_ack = 1'b0;
    chk("f2_head", 32'(h_hd), 7);
    chk("f2_tail", 32'(h_tl), 6);
    chk("f2_count7", 32'(h_cnt), 7);
    chk("f2_count7_t", 32'(t_cnt), 7);

    do_flush("flush2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
